// File: rtl/nn_result_tx.sv
// Result transmitter: argmax over captured class scores, then a framed byte stream over a four-phase req/ack handshake.
// Frame: HEADER, raw scores, class index, running XOR checksum; ack is resynchronised before use.
module nn_result_tx #(
  parameter int          N_CLASSES = 10,
  parameter int          SCORE_W   = 8,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         scores_valid,
  input  logic [N_CLASSES*SCORE_W-1:0] scores_in,
  output logic                         busy,
  output logic [3:0]                   class_out,
  output logic                         class_valid,
  output logic [7:0]                   tx_data,
  output logic                         tx_req,
  input  logic                         tx_ack,
  output logic                         frame_done
);

  localparam int              PTR_W    = 5;
  localparam logic [3:0]      LAST_IDX = 4'(N_CLASSES - 1);
  localparam logic [PTR_W-1:0] N_PTR    = PTR_W'(N_CLASSES);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_CLASSES + 2);

  typedef enum logic [1:0] {IDLE, ARGMAX, REQ, REL} state_t;

  state_t                     state, state_nxt;
  logic                       ack_meta, ack_s;
  logic signed [SCORE_W-1:0]  score [N_CLASSES];
  logic signed [SCORE_W-1:0]  best, best_nxt;
  logic [3:0]                 idx, idx_nxt;
  logic [3:0]                 bidx, bidx_nxt;
  logic [PTR_W-1:0]           ptr, ptr_nxt;
  logic [7:0]                 chk, chk_nxt;
  logic [7:0]                 load_byte;
  logic [7:0]                 tx_data_nxt;
  logic [3:0]                 class_out_nxt;
  logic                       busy_nxt, class_valid_nxt, tx_req_nxt, frame_done_nxt;
  logic                       capture, take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= tx_ack;
      ack_s    <= ack_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CLASSES; k++) score[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < N_CLASSES; k++) score[k] <= scores_in[k*SCORE_W +: SCORE_W];
    end
  end

  assign take = (score[idx] > best);

  // Byte following the current pointer; the checksum slot sees the XOR of everything loaded so far.
  always_comb begin
    load_byte = chk;
    if (ptr < N_PTR)
      load_byte = score[ptr[3:0]];
    else if (ptr == N_PTR)
      load_byte = {4'b0000, class_out};
  end

  always_comb begin
    state_nxt       = state;
    best_nxt        = best;
    idx_nxt         = idx;
    bidx_nxt        = bidx;
    ptr_nxt         = ptr;
    chk_nxt         = chk;
    tx_data_nxt     = tx_data;
    class_out_nxt   = class_out;
    busy_nxt        = busy;
    class_valid_nxt = class_valid;
    tx_req_nxt      = tx_req;
    frame_done_nxt  = 1'b0;
    capture         = 1'b0;
    case (state)
      IDLE: begin
        if (scores_valid) begin
          capture         = 1'b1;
          best_nxt        = scores_in[SCORE_W-1:0];
          bidx_nxt        = 4'd0;
          idx_nxt         = 4'd1;
          class_valid_nxt = 1'b0;
          busy_nxt        = 1'b1;
          state_nxt       = ARGMAX;
        end
      end
      ARGMAX: begin
        if (take) begin
          best_nxt = score[idx];
          bidx_nxt = idx;
        end
        if (idx == LAST_IDX) begin
          class_out_nxt   = take ? idx : bidx;
          class_valid_nxt = 1'b1;
          ptr_nxt         = '0;
          tx_data_nxt     = HEADER;
          chk_nxt         = HEADER;
          state_nxt       = REQ;
        end else begin
          idx_nxt = idx + 4'd1;
        end
      end
      REQ: begin
        // Never raise req into an ack that is still high.
        if (tx_req && ack_s) begin
          tx_req_nxt = 1'b0;
          state_nxt  = REL;
        end else if (!tx_req && !ack_s) begin
          tx_req_nxt = 1'b1;
        end
      end
      REL: begin
        if (!ack_s) begin
          if (ptr == LAST_PTR) begin
            frame_done_nxt = 1'b1;
            busy_nxt       = 1'b0;
            state_nxt      = IDLE;
          end else begin
            ptr_nxt     = ptr + 1'b1;
            tx_data_nxt = load_byte;
            chk_nxt     = chk ^ load_byte;
            state_nxt   = REQ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      best        <= '0;
      idx         <= '0;
      bidx        <= '0;
      ptr         <= '0;
      chk         <= '0;
      tx_data     <= '0;
      class_out   <= '0;
      busy        <= 1'b0;
      class_valid <= 1'b0;
      tx_req      <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      best        <= best_nxt;
      idx         <= idx_nxt;
      bidx        <= bidx_nxt;
      ptr         <= ptr_nxt;
      chk         <= chk_nxt;
      tx_data     <= tx_data_nxt;
      class_out   <= class_out_nxt;
      busy        <= busy_nxt;
      class_valid <= class_valid_nxt;
      tx_req      <= tx_req_nxt;
      frame_done  <= frame_done_nxt;
    end
  end

endmodule
